// File: rtl/fm_demod_pkg.sv
// Shared definitions for the FM demodulator controller and its datapath.
package fm_demod_pkg;

  localparam int unsigned FM_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MULT,
    EMIT
  } state_t;

endpackage

// File: rtl/fm_demod_ctrl.sv
// Sequencing controller for the conjugate-complex-multiply FM demodulator:
// sample buffering, load/start strobes and primed qualification of the output.
module fm_demod_ctrl
  import fm_demod_pkg::*;
#(
  parameter int unsigned WIDTH = FM_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid_i,
  output logic             sample_ready_o,
  input  logic [WIDTH-1:0] real_i,
  input  logic [WIDTH-1:0] imag_i,
  output logic [WIDTH-1:0] real_o,
  output logic [WIDTH-1:0] imag_o,
  output logic             load_o,
  output logic             start_o,
  input  logic [WIDTH-1:0] demod_i,
  output logic [WIDTH-1:0] demod_o,
  output logic             demod_valid_o,
  input  logic             demod_ready_i,
  input  logic             flush_i,
  output logic             primed_o,
  output logic [CNT_W-1:0] out_cnt_o
);

  state_t state, state_nx;
  logic   accept;
  logic   deliver;

  assign demod_o = demod_i;

  always_comb begin
    state_nx       = state;
    sample_ready_o = 1'b0;
    load_o         = 1'b0;
    start_o        = 1'b0;
    demod_valid_o  = 1'b0;
    accept         = 1'b0;
    deliver        = 1'b0;
    case (state)
      IDLE: begin
        sample_ready_o = 1'b1;
        if (sample_valid_i) begin
          accept   = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        load_o   = 1'b1;
        state_nx = MULT;
      end
      MULT: begin
        start_o  = 1'b1;
        state_nx = EMIT;
      end
      EMIT: begin
        // A flush withdraws a pending output unless the handshake lands in the same cycle.
        if (primed_o) begin
          demod_valid_o = 1'b1;
          if (demod_ready_i) begin
            deliver  = 1'b1;
            state_nx = IDLE;
          end else if (flush_i) begin
            state_nx = IDLE;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      real_o    <= '0;
      imag_o    <= '0;
      primed_o  <= 1'b0;
      out_cnt_o <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        real_o <= real_i;
        imag_o <= imag_i;
      end
      if (deliver) out_cnt_o <= out_cnt_o + 1'b1;
      if (flush_i) primed_o <= 1'b0;
      else if (state == EMIT && !primed_o) primed_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fm_demod_ctrl.sv
// Self-checking bench for fm_demod_ctrl with a behavioural datapath and a
// transaction-level reference of which samples produce which outputs.
module tb_fm_demod_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sample_valid_i = 1'b0;
  logic                 sample_ready_o;
  logic signed [W-1:0]  real_i = '0;
  logic signed [W-1:0]  imag_i = '0;
  logic signed [W-1:0]  real_o;
  logic signed [W-1:0]  imag_o;
  logic                 load_o;
  logic                 start_o;
  logic signed [W-1:0]  demod_i;
  logic signed [W-1:0]  demod_o;
  logic                 demod_valid_o;
  logic                 demod_ready_i = 1'b0;
  logic                 flush_i = 1'b0;
  logic                 primed_o;
  logic [CW-1:0]        out_cnt_o;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  fm_demod_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .real_i(real_i), .imag_i(imag_i), .real_o(real_o), .imag_o(imag_o),
    .load_o(load_o), .start_o(start_o),
    .demod_i(demod_i), .demod_o(demod_o),
    .demod_valid_o(demod_valid_o), .demod_ready_i(demod_ready_i),
    .flush_i(flush_i), .primed_o(primed_o), .out_cnt_o(out_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic signed [W-1:0] ref_demod(longint cr, longint ci, longint pr, longint pi);
    longint p;
    p = (ci * pr - cr * pi) >>> 8;
    return p[W-1:0];
  endfunction

  // Behavioural datapath: loads the sample on load_o, registers the product on start_o.
  logic signed [W-1:0] dp_cr, dp_ci, dp_pr, dp_pi, dp_prod;
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_cr <= '0; dp_ci <= '0; dp_pr <= '0; dp_pi <= '0; dp_prod <= '0;
    end else begin
      if (load_o) begin
        dp_pr <= dp_cr; dp_pi <= dp_ci;
        dp_cr <= real_o; dp_ci <= imag_o;
      end
      if (start_o) dp_prod <= ref_demod(dp_cr, dp_ci, dp_pr, dp_pi);
    end
  end
  assign demod_i = dp_prod;

  // Reference model state
  logic signed [W-1:0] exp_q[$];
  logic signed [W-1:0] obs_q[$];
  int                  acc_cycles[$];
  bit                  model_primed = 1'b0;
  logic signed [W-1:0] last_r = '0, last_i = '0;
  logic [CW-1:0]       model_cnt = '0;

  task automatic step();
    bit acc, hs, rs;
    logic signed [W-1:0] r, i, d;
    rs  = rst;
    acc = sample_valid_i && sample_ready_o;
    hs  = demod_valid_o && demod_ready_i;
    r = real_i; i = imag_i; d = demod_o;
    @(posedge clk); #1;
    cycle++;
    if (rs) begin
      exp_q.delete(); obs_q.delete();
      model_primed = 1'b0; last_r = '0; last_i = '0; model_cnt = '0;
    end else begin
      if (hs) begin
        obs_q.push_back(d);
        model_cnt = model_cnt + 1'b1;
      end
      if (acc) begin
        if (model_primed) exp_q.push_back(ref_demod(r, i, last_r, last_i));
        model_primed = 1'b1;
        last_r = r; last_i = i;
        acc_cycles.push_back(cycle);
      end
    end
  endtask

  function automatic logic signed [W-1:0] rnd();
    return W'($urandom_range(0, 65535));
  endfunction

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    checks++; if (sample_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", sample_ready_o); end
    checks++; if ({load_o, start_o, demod_valid_o} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {load_o, start_o, demod_valid_o}); end
    checks++; if (primed_o !== 1'b0) begin failures++; $display("FAIL reset_primed got=%b exp=0", primed_o); end
    checks++; if (out_cnt_o !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", out_cnt_o); end
    checks++; if (real_o !== '0 || imag_o !== '0) begin failures++; $display("FAIL reset_iq got=%0d,%0d exp=0,0", real_o, imag_o); end
  endtask

  task automatic test_first_sample();
    logic signed [W-1:0] e;
    demod_ready_i = 1'b1;
    sample_valid_i = 1'b1; real_i = 16'sd1000; imag_i = 16'sd0;
    step(); sample_valid_i = 1'b0; real_i = rnd(); imag_i = rnd();
    checks++; if ({load_o, start_o, sample_ready_o} !== 3'b100) begin failures++; $display("FAIL first_load got=%b exp=100", {load_o, start_o, sample_ready_o}); end
    checks++; if (real_o !== 16'sd1000 || imag_o !== 16'sd0) begin failures++; $display("FAIL first_iq got=%0d,%0d exp=1000,0", real_o, imag_o); end
    step();
    checks++; if ({load_o, start_o} !== 2'b01) begin failures++; $display("FAIL first_start got=%b exp=01", {load_o, start_o}); end
    step();
    checks++; if (demod_valid_o !== 1'b0 || primed_o !== 1'b0) begin failures++; $display("FAIL first_unprimed got=%b%b exp=00", demod_valid_o, primed_o); end
    step();
    checks++; if (primed_o !== 1'b1 || sample_ready_o !== 1'b1 || out_cnt_o !== '0) begin failures++; $display("FAIL first_primed got=%b%b cnt=%0d exp=11 cnt=0", primed_o, sample_ready_o, out_cnt_o); end
    sample_valid_i = 1'b1; real_i = 16'sd1000; imag_i = 16'sd1000;
    step(); sample_valid_i = 1'b0;
    step(); step();
    e = ref_demod(1000, 1000, 1000, 0);
    checks++; if (demod_valid_o !== 1'b1 || demod_o !== e) begin failures++; $display("FAIL second_output got=%b/%0d exp=1/%0d", demod_valid_o, demod_o, e); end
    step();
    checks++; if (out_cnt_o !== CW'(1) || demod_valid_o !== 1'b0) begin failures++; $display("FAIL second_count got=%0d/%b exp=1/0", out_cnt_o, demod_valid_o); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    bit prev_load = 1'b0;
    acc_cycles.delete();
    demod_ready_i = 1'b1; sample_valid_i = 1'b1;
    for (int n = 0; n < 41; n++) begin
      real_i = rnd(); imag_i = rnd();
      step();
      checks++; if (int'(load_o) + int'(start_o) + int'(demod_valid_o) + int'(sample_ready_o) > 1) begin failures++; $display("FAIL b2b_exclusive got=%b%b%b%b", load_o, start_o, demod_valid_o, sample_ready_o); end
      checks++; if (prev_load && (load_o || !start_o)) begin failures++; $display("FAIL b2b_pulse got load=%b start=%b exp load=0 start=1", load_o, start_o); end
      prev_load = load_o;
    end
    sample_valid_i = 1'b0;
    for (int n = 0; n < 4; n++) step();
    checks++; if (acc_cycles.size() < 9) begin failures++; $display("FAIL b2b_accepts got=%0d exp>=9", acc_cycles.size()); end
    for (int k = 1; k < acc_cycles.size(); k++) begin
      checks++; if (acc_cycles[k] - acc_cycles[k-1] != 4) begin failures++; $display("FAIL b2b_interval got=%0d exp=4", acc_cycles[k] - acc_cycles[k-1]); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_outputs got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic signed [W-1:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL b2b_data got=%0d exp=%0d", o, e); end
    end
    checks++; if (out_cnt_o !== model_cnt) begin failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", out_cnt_o, model_cnt); end
  endtask

  task automatic test_backpressure();
    logic signed [W-1:0] d0;
    logic [CW-1:0] c0;
    int n = 0;
    demod_ready_i = 1'b0;
    sample_valid_i = 1'b1; real_i = rnd(); imag_i = rnd();
    step(); sample_valid_i = 1'b0;
    while (!demod_valid_o && n < 8) begin step(); n++; end
    checks++; if (!demod_valid_o) begin failures++; $display("FAIL bp_valid_timeout got=0 exp=1"); end
    d0 = demod_o; c0 = out_cnt_o;
    for (int k = 0; k < 10; k++) begin
      sample_valid_i = 1'b1;
      step();
      checks++; if (demod_valid_o !== 1'b1 || demod_o !== d0 || sample_ready_o !== 1'b0) begin failures++; $display("FAIL bp_hold got=%b/%0d/%b exp=1/%0d/0", demod_valid_o, demod_o, sample_ready_o, d0); end
    end
    sample_valid_i = 1'b0; demod_ready_i = 1'b1;
    step();
    checks++; if (out_cnt_o !== c0 + 1'b1 || sample_ready_o !== 1'b1) begin failures++; $display("FAIL bp_release got=%0d/%b exp=%0d/1", out_cnt_o, sample_ready_o, c0 + 1'b1); end
  endtask

  task automatic test_flush();
    logic signed [W-1:0] s1r, s1i, s2r, s2i, e;
    logic [CW-1:0] c0;
    int n = 0;
    // flush during MULT: in-flight product discarded, stream re-primes
    demod_ready_i = 1'b1;
    s1r = rnd(); s1i = rnd();
    sample_valid_i = 1'b1; real_i = s1r; imag_i = s1i;
    step(); sample_valid_i = 1'b0;
    step();
    flush_i = 1'b1; step(); flush_i = 1'b0;
    checks++; if (demod_valid_o !== 1'b0 || primed_o !== 1'b0) begin failures++; $display("FAIL flush_mult_emit got=%b%b exp=00", demod_valid_o, primed_o); end
    void'(exp_q.pop_back());
    step();
    checks++; if (primed_o !== 1'b1 || sample_ready_o !== 1'b1) begin failures++; $display("FAIL flush_reprime got=%b%b exp=11", primed_o, sample_ready_o); end
    s2r = rnd(); s2i = rnd();
    sample_valid_i = 1'b1; real_i = s2r; imag_i = s2i;
    step(); sample_valid_i = 1'b0;
    step(); step();
    e = ref_demod(s2r, s2i, s1r, s1i);
    checks++; if (demod_valid_o !== 1'b1 || demod_o !== e) begin failures++; $display("FAIL flush_next got=%b/%0d exp=1/%0d", demod_valid_o, demod_o, e); end
    step();
    // flush while a valid output waits: withdrawn, not counted
    demod_ready_i = 1'b0;
    sample_valid_i = 1'b1; real_i = rnd(); imag_i = rnd();
    step(); sample_valid_i = 1'b0;
    while (!demod_valid_o && n < 8) begin step(); n++; end
    checks++; if (!demod_valid_o) begin failures++; $display("FAIL flush_wd_timeout got=0 exp=1"); end
    c0 = out_cnt_o;
    flush_i = 1'b1; step(); flush_i = 1'b0;
    checks++; if (demod_valid_o !== 1'b0 || sample_ready_o !== 1'b1 || out_cnt_o !== c0 || primed_o !== 1'b0) begin failures++; $display("FAIL flush_withdraw got=%b%b%b cnt=%0d exp=010 cnt=%0d", demod_valid_o, sample_ready_o, primed_o, out_cnt_o, c0); end
    void'(exp_q.pop_back());
    model_primed = 1'b0;
    demod_ready_i = 1'b1;
    sample_valid_i = 1'b1; real_i = rnd(); imag_i = rnd();
    step(); sample_valid_i = 1'b0;
    step(); step();
    checks++; if (demod_valid_o !== 1'b0) begin failures++; $display("FAIL flush_unprimed_emit got=%b exp=0", demod_valid_o); end
    step();
    checks++; if (primed_o !== 1'b1) begin failures++; $display("FAIL flush_primed_after got=%b exp=1", primed_o); end
  endtask

  task automatic test_wrap();
    logic [CW-1:0] c0;
    int n = 0;
    demod_ready_i = 1'b1; sample_valid_i = 1'b1;
    while (out_cnt_o !== '1 && n < 2000) begin real_i = rnd(); imag_i = rnd(); step(); n++; end
    checks++; if (out_cnt_o !== '1) begin failures++; $display("FAIL wrap_reach_max got=%0d exp=%0d", out_cnt_o, {CW{1'b1}}); end
    c0 = out_cnt_o; n = 0;
    while (out_cnt_o === c0 && n < 8) begin step(); n++; end
    sample_valid_i = 1'b0;
    checks++; if (out_cnt_o !== '0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", out_cnt_o); end
    checks++; if (out_cnt_o !== model_cnt) begin failures++; $display("FAIL wrap_model got=%0d exp=%0d", out_cnt_o, model_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      sample_valid_i = ($urandom_range(0, 1) == 1);
      demod_ready_i  = ($urandom_range(0, 9) < 6);
      real_i = rnd(); imag_i = rnd();
      step();
    end
    sample_valid_i = 1'b0; demod_ready_i = 1'b1;
    for (int n = 0; n < 6; n++) step();
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_outputs got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic signed [W-1:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL rand_data got=%0d exp=%0d", o, e); end
    end
    checks++; if (out_cnt_o !== model_cnt) begin failures++; $display("FAIL rand_cnt got=%0d exp=%0d", out_cnt_o, model_cnt); end
  endtask

  task automatic test_reset_mid_emit();
    int n = 0;
    demod_ready_i = 1'b0;
    sample_valid_i = 1'b1; real_i = rnd() | 16'sh0101; imag_i = rnd() | 16'sh0101;
    step(); sample_valid_i = 1'b0;
    while (!demod_valid_o && n < 8) begin step(); n++; end
    checks++; if (!demod_valid_o) begin failures++; $display("FAIL rst_emit_timeout got=0 exp=1"); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if ({sample_ready_o, load_o, start_o, demod_valid_o, primed_o} !== 5'b10000) begin failures++; $display("FAIL rst_mid_ctrl got=%b exp=10000", {sample_ready_o, load_o, start_o, demod_valid_o, primed_o}); end
    checks++; if (out_cnt_o !== '0 || real_o !== '0 || imag_o !== '0) begin failures++; $display("FAIL rst_mid_regs got=%0d/%0d/%0d exp=0/0/0", out_cnt_o, real_o, imag_o); end
    checks++; if (demod_o !== demod_i) begin failures++; $display("FAIL rst_mid_demod got=%0d exp=%0d", demod_o, demod_i); end
    demod_ready_i = 1'b1;
    sample_valid_i = 1'b1; real_i = rnd(); imag_i = rnd();
    step(); sample_valid_i = 1'b0;
    step(); step();
    checks++; if (demod_valid_o !== 1'b0 || primed_o !== 1'b0) begin failures++; $display("FAIL rst_post_unprimed got=%b%b exp=00", demod_valid_o, primed_o); end
    step();
    checks++; if (primed_o !== 1'b1 || out_cnt_o !== '0) begin failures++; $display("FAIL rst_post_primed got=%b cnt=%0d exp=1 cnt=0", primed_o, out_cnt_o); end
  endtask

  initial begin
    #1;
    test_reset();
    test_first_sample();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_wrap();
    test_random();
    test_reset_mid_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
